// File: rtl/id_pipe_pkg.sv
// Shared decode constants for the id_pipe RV32I decode stage.
// Opcodes, funct codes, EX operation/result-select codes and reset levels.
package id_pipe_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [7:0] EXE_NOP_OP   = 8'h00;
    localparam logic [7:0] EXE_ADD_OP   = 8'h01;
    localparam logic [7:0] EXE_SUB_OP   = 8'h02;
    localparam logic [7:0] EXE_SLL_OP   = 8'h03;
    localparam logic [7:0] EXE_SLT_OP   = 8'h04;
    localparam logic [7:0] EXE_SLTU_OP  = 8'h05;
    localparam logic [7:0] EXE_XOR_OP   = 8'h06;
    localparam logic [7:0] EXE_SRL_OP   = 8'h07;
    localparam logic [7:0] EXE_SRA_OP   = 8'h08;
    localparam logic [7:0] EXE_OR_OP    = 8'h09;
    localparam logic [7:0] EXE_AND_OP   = 8'h0A;
    localparam logic [7:0] EXE_LUI_OP   = 8'h0B;
    localparam logic [7:0] EXE_AUIPC_OP = 8'h0C;
    localparam logic [7:0] EXE_JAL_OP   = 8'h0D;
    localparam logic [7:0] EXE_JALR_OP  = 8'h0E;
    // Branch/load/store codes carry funct3 in their low bits.
    localparam logic [7:0] EXE_BR_OP    = 8'h10;
    localparam logic [7:0] EXE_LD_OP    = 8'h20;
    localparam logic [7:0] EXE_ST_OP    = 8'h28;

    localparam logic [2:0] EXE_RES_NOP    = 3'd0;
    localparam logic [2:0] EXE_RES_LOGIC  = 3'd1;
    localparam logic [2:0] EXE_RES_SHIFT  = 3'd2;
    localparam logic [2:0] EXE_RES_ARITH  = 3'd3;
    localparam logic [2:0] EXE_RES_JUMP   = 3'd4;
    localparam logic [2:0] EXE_RES_LOAD   = 3'd5;
    localparam logic [2:0] EXE_RES_STORE  = 3'd6;
    localparam logic [2:0] EXE_RES_BRANCH = 3'd7;

    localparam logic [31:0] ZeroWord     = 32'h0;
    localparam logic [4:0]  NOPRegAddr   = 5'd0;
    localparam logic        RstEnable    = 1'b0;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;

    function automatic logic [7:0] alu_op(
        input logic [2:0] f3,
        input logic       alt
    );
        logic [7:0] r;
        unique case (f3)
            F3_ADD:  r = alt ? EXE_SUB_OP : EXE_ADD_OP;
            F3_SLL:  r = EXE_SLL_OP;
            F3_SLT:  r = EXE_SLT_OP;
            F3_SLTU: r = EXE_SLTU_OP;
            F3_XOR:  r = EXE_XOR_OP;
            F3_SR:   r = alt ? EXE_SRA_OP : EXE_SRL_OP;
            F3_OR:   r = EXE_OR_OP;
            default: r = EXE_AND_OP;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] alu_sel(input logic [2:0] f3);
        logic [2:0] r;
        unique case (f3)
            F3_SLL, F3_SR:          r = EXE_RES_SHIFT;
            F3_ADD, F3_SLT, F3_SLTU: r = EXE_RES_ARITH;
            default:                r = EXE_RES_LOGIC;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/id_pipe_if.sv
// Fetch-side and EX-side valid/ready handshakes of the decode stage.
interface id_pipe_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_inst;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid
    );
    modport slave (
        input  in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid
    );
endinterface

// File: rtl/id_fifo.sv
// Circular input buffer for fetched {pc, inst}; DEPTH must be a power of two.
module id_fifo
    import id_pipe_pkg::*;
#(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_empty,
    output logic         o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_data  = r_mem[r_rp];

    always_ff @(posedge clk) begin
        if (rst == RstEnable || i_flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wp] <= i_data;
                r_wp        <= r_wp + AW'(1);
            end
            if (i_pop)
                r_rp <= r_rp + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end
endmodule

// File: rtl/id_pipe.sv
// RV32I decode stage: input buffer, decode, bypass/hazard, ID/EX register.
// ID_FORWARD_EN enables EX/MEM bypass; otherwise matching sources stall.
module id_pipe
    import id_pipe_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SKID_DEPTH = 2,
    parameter int ALUOP_W    = 8,
    parameter int ALUSEL_W   = 3
) (
    input  logic                clk,
    input  logic                rst,
    id_pipe_if.slave            hs,
    output logic                reg1_read_o,
    output logic                reg2_read_o,
    output logic [4:0]          reg1_addr_o,
    output logic [4:0]          reg2_addr_o,
    input  logic [XLEN-1:0]     reg1_data_i,
    input  logic [XLEN-1:0]     reg2_data_i,
    input  logic                ex_wreg_i,
    input  logic [4:0]          ex_wd_i,
    input  logic [XLEN-1:0]     ex_wdata_i,
    input  logic                ex_is_load_i,
    input  logic                mem_wreg_i,
    input  logic [4:0]          mem_wd_i,
    input  logic [XLEN-1:0]     mem_wdata_i,
    input  logic                flush_i,
    output logic [XLEN-1:0]     out_pc,
    output logic [ALUOP_W-1:0]  aluop_o,
    output logic [ALUSEL_W-1:0] alusel_o,
    output logic [XLEN-1:0]     reg1_o,
    output logic [XLEN-1:0]     reg2_o,
    output logic [XLEN-1:0]     imm_o,
    output logic [4:0]          wd_o,
    output logic                wreg_o,
    output logic                illegal_o
);
    function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
        return {{(XLEN-31){v[31]}}, v[30:0]};
    endfunction

    logic             w_empty, w_full, w_push, w_adv, w_hazard;
    logic [XLEN+31:0] w_head;
    logic [XLEN-1:0]  w_pc;
    logic [31:0]      w_inst;
    logic             r_out_valid;

    assign {w_pc, w_inst} = w_head;
    assign hs.in_ready    = !w_full;
    assign hs.out_valid   = r_out_valid;
    assign w_push         = hs.in_valid && !w_full && !flush_i;

    id_fifo #(.W(XLEN + 32), .DEPTH(SKID_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_adv),
        .i_flush (flush_i),
        .i_data  ({hs.in_pc, hs.in_inst}),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

    assign w_opc   = w_inst[6:0];
    assign w_f3    = w_inst[14:12];
    assign w_rd    = w_inst[11:7];
    assign w_rs1   = w_inst[19:15];
    assign w_rs2   = w_inst[24:20];
    assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
    assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7],
                      w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_imm_u = {w_inst[31:12], 12'b0};
    assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12],
                      w_inst[20], w_inst[30:21], 1'b0};

    logic        w_use1, w_use2, w_wreg, w_illegal, w_r1_pc, w_r2_imm;
    logic [7:0]  w_aluop;
    logic [2:0]  w_alusel;
    logic [31:0] w_imm;

    always_comb begin
        w_use1    = 1'b0;
        w_use2    = 1'b0;
        w_wreg    = WriteDisable;
        w_illegal = 1'b0;
        w_r1_pc   = 1'b0;
        w_r2_imm  = 1'b0;
        w_aluop   = EXE_NOP_OP;
        w_alusel  = EXE_RES_NOP;
        w_imm     = ZeroWord;
        unique case (w_opc)
            OPC_OP_IMM: begin
                w_use1 = 1'b1; w_wreg = WriteEnable; w_r2_imm = 1'b1;
                w_imm  = w_imm_i;
                w_aluop  = alu_op(w_f3, (w_f3 == F3_SR) && w_inst[30]);
                w_alusel = alu_sel(w_f3);
            end
            OPC_OP: begin
                w_use1 = 1'b1; w_use2 = 1'b1; w_wreg = WriteEnable;
                w_aluop  = alu_op(w_f3, w_inst[31:25] == F7_ALT);
                w_alusel = alu_sel(w_f3);
            end
            OPC_LUI: begin
                w_wreg = WriteEnable; w_r2_imm = 1'b1; w_imm = w_imm_u;
                w_aluop = EXE_LUI_OP; w_alusel = EXE_RES_ARITH;
            end
            OPC_AUIPC: begin
                w_wreg = WriteEnable; w_r1_pc = 1'b1; w_r2_imm = 1'b1;
                w_imm = w_imm_u; w_aluop = EXE_AUIPC_OP;
                w_alusel = EXE_RES_ARITH;
            end
            OPC_JAL: begin
                w_wreg = WriteEnable; w_r1_pc = 1'b1; w_r2_imm = 1'b1;
                w_imm = w_imm_j; w_aluop = EXE_JAL_OP;
                w_alusel = EXE_RES_JUMP;
            end
            OPC_JALR: begin
                w_use1 = 1'b1; w_wreg = WriteEnable; w_r2_imm = 1'b1;
                w_imm = w_imm_i; w_aluop = EXE_JALR_OP;
                w_alusel = EXE_RES_JUMP;
            end
            OPC_BRANCH: begin
                w_use1 = 1'b1; w_use2 = 1'b1; w_imm = w_imm_b;
                w_aluop = EXE_BR_OP | {5'd0, w_f3};
                w_alusel = EXE_RES_BRANCH;
            end
            OPC_LOAD: begin
                w_use1 = 1'b1; w_wreg = WriteEnable; w_r2_imm = 1'b1;
                w_imm = w_imm_i; w_aluop = EXE_LD_OP | {5'd0, w_f3};
                w_alusel = EXE_RES_LOAD;
            end
            OPC_STORE: begin
                w_use1 = 1'b1; w_use2 = 1'b1; w_imm = w_imm_s;
                w_aluop = EXE_ST_OP | {5'd0, w_f3};
                w_alusel = EXE_RES_STORE;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    logic            w_ex1, w_ex2, w_mem1, w_mem2;
    logic [XLEN-1:0] w_src1, w_src2, w_op1, w_op2;

    assign w_ex1  = ex_wreg_i  && (ex_wd_i  == w_rs1) && (w_rs1 != 5'd0);
    assign w_ex2  = ex_wreg_i  && (ex_wd_i  == w_rs2) && (w_rs2 != 5'd0);
    assign w_mem1 = mem_wreg_i && (mem_wd_i == w_rs1) && (w_rs1 != 5'd0);
    assign w_mem2 = mem_wreg_i && (mem_wd_i == w_rs2) && (w_rs2 != 5'd0);

`ifdef ID_FORWARD_EN
    assign w_src1 = w_ex1 ? ex_wdata_i : w_mem1 ? mem_wdata_i :
                    (w_rs1 == 5'd0) ? '0 : reg1_data_i;
    assign w_src2 = w_ex2 ? ex_wdata_i : w_mem2 ? mem_wdata_i :
                    (w_rs2 == 5'd0) ? '0 : reg2_data_i;
    assign w_hazard = ex_is_load_i &&
                      ((w_use1 && w_ex1) || (w_use2 && w_ex2));
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{ex_wdata_i, mem_wdata_i, ex_is_load_i};
    assign w_src1 = (w_rs1 == 5'd0) ? '0 : reg1_data_i;
    assign w_src2 = (w_rs2 == 5'd0) ? '0 : reg2_data_i;
    assign w_hazard = (w_use1 && (w_ex1 || w_mem1)) ||
                      (w_use2 && (w_ex2 || w_mem2));
`endif

    assign w_op1 = w_r1_pc  ? w_pc    : w_use1 ? w_src1 : '0;
    assign w_op2 = w_r2_imm ? sx(w_imm) : w_use2 ? w_src2 : '0;

    assign reg1_read_o = !w_empty && w_use1;
    assign reg2_read_o = !w_empty && w_use2;
    assign reg1_addr_o = w_rs1;
    assign reg2_addr_o = w_rs2;

    assign w_adv = !w_empty && !w_hazard && !flush_i &&
                   (!r_out_valid || hs.out_ready);

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_out_valid <= 1'b0;
            out_pc      <= '0;
            aluop_o     <= ALUOP_W'(EXE_NOP_OP);
            alusel_o    <= ALUSEL_W'(EXE_RES_NOP);
            reg1_o      <= '0;
            reg2_o      <= '0;
            imm_o       <= '0;
            wd_o        <= NOPRegAddr;
            wreg_o      <= WriteDisable;
            illegal_o   <= 1'b0;
        end else if (flush_i) begin
            r_out_valid <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= 1'b1;
            out_pc      <= w_pc;
            aluop_o     <= ALUOP_W'(w_aluop);
            alusel_o    <= ALUSEL_W'(w_alusel);
            reg1_o      <= w_op1;
            reg2_o      <= w_op2;
            imm_o       <= sx(w_imm);
            wd_o        <= w_wreg ? w_rd : NOPRegAddr;
            wreg_o      <= w_wreg;
            illegal_o   <= w_illegal;
        end else if (hs.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_id_pipe.sv
// Directed testbench for id_pipe with hand-computed expectations.
module tb_id_pipe;
    import id_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    id_pipe_if #(.XLEN(32)) bus ();

    logic        reg1_read_o, reg2_read_o;
    logic [4:0]  reg1_addr_o, reg2_addr_o;
    logic [31:0] reg1_data_i, reg2_data_i;
    logic        ex_wreg_i = 1'b0, ex_is_load_i = 1'b0;
    logic [4:0]  ex_wd_i = 5'd0;
    logic [31:0] ex_wdata_i = 32'h0;
    logic        mem_wreg_i = 1'b0;
    logic [4:0]  mem_wd_i = 5'd0;
    logic [31:0] mem_wdata_i = 32'h0;
    logic        flush_i = 1'b0;
    logic [31:0] out_pc, reg1_o, reg2_o, imm_o;
    logic [7:0]  aluop_o;
    logic [2:0]  alusel_o;
    logic [4:0]  wd_o;
    logic        wreg_o, illegal_o;

    // Register file model: x<n> reads 0x1000 + n.
    assign reg1_data_i = 32'h1000 + 32'(reg1_addr_o);
    assign reg2_data_i = 32'h1000 + 32'(reg2_addr_o);

    id_pipe #(
        .XLEN(32), .SKID_DEPTH(2), .ALUOP_W(8), .ALUSEL_W(3)
    ) dut (
        .clk(clk), .rst(rst), .hs(bus),
        .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
        .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i),
        .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
        .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i),
        .mem_wdata_i(mem_wdata_i), .flush_i(flush_i),
        .out_pc(out_pc), .aluop_o(aluop_o), .alusel_o(alusel_o),
        .reg1_o(reg1_o), .reg2_o(reg2_o), .imm_o(imm_o),
        .wd_o(wd_o), .wreg_o(wreg_o), .illegal_o(illegal_o)
    );

    int vecs = 0;
    int errs = 0;
    int acc  = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst);
        bus.in_valid = 1'b1;
        bus.in_pc    = pc;
        bus.in_inst  = inst;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_pc     = 32'h0;
        bus.in_inst   = 32'h0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_ready", 32'(bus.in_ready), 1);
        chk("rst_aluop", 32'(aluop_o), 32'(EXE_NOP_OP));
        chk("rst_wreg", 32'(wreg_o), 0);
        chk("rst_reg2", reg2_o, 0);
        rst = 1'b1;

        // ori x1,x0,10
        push(32'h100, 32'h00A06093);
        chk("ori_lat", 32'(bus.out_valid), 0);
        chk("ori_rd1", 32'(reg1_read_o), 1);
        chk("ori_rd2", 32'(reg2_read_o), 0);
        tick();
        chk("ori_valid", 32'(bus.out_valid), 1);
        chk("ori_pc", out_pc, 32'h100);
        chk("ori_reg1", reg1_o, 0);
        chk("ori_reg2", reg2_o, 10);
        chk("ori_imm", imm_o, 10);
        chk("ori_wd", 32'(wd_o), 1);
        chk("ori_wreg", 32'(wreg_o), 1);
        chk("ori_aluop", 32'(aluop_o), 32'h09);
        chk("ori_alusel", 32'(alusel_o), 32'(EXE_RES_LOGIC));
        tick();
        chk("ori_drop", 32'(bus.out_valid), 0);

        // addi x4,x3,5 with EX and MEM both targeting x3
        ex_wreg_i = 1'b1; ex_wd_i = 5'd3; ex_wdata_i = 32'h1234;
        mem_wreg_i = 1'b1; mem_wd_i = 5'd3; mem_wdata_i = 32'h9999;
        push(32'h104, 32'h00518213);
        tick();
`ifdef ID_FORWARD_EN
        chk("fwd_valid", 32'(bus.out_valid), 1);
        chk("fwd_ex", reg1_o, 32'h1234);
        chk("fwd_imm", reg2_o, 5);
        ex_wreg_i = 1'b0;
        push(32'h108, 32'h00518213);
        tick();
        chk("fwd_mem", reg1_o, 32'h9999);
        mem_wreg_i = 1'b0;
`else
        chk("stall_ex", 32'(bus.out_valid), 0);
        ex_wreg_i = 1'b0;
        tick();
        chk("stall_mem", 32'(bus.out_valid), 0);
        mem_wreg_i = 1'b0;
        tick();
        chk("nofwd_valid", 32'(bus.out_valid), 1);
        chk("nofwd_rf", reg1_o, 32'h1003);
        chk("nofwd_imm", reg2_o, 5);
`endif
        tick();

        // add x6,x5,x5 behind a load to x5
        ex_wreg_i = 1'b1; ex_wd_i = 5'd5; ex_is_load_i = 1'b1;
        ex_wdata_i = 32'h5555;
        push(32'h10C, 32'h00528333);
        tick();
        chk("lu_bubble", 32'(bus.out_valid), 0);
        ex_wreg_i = 1'b0; ex_is_load_i = 1'b0;
        mem_wreg_i = 1'b1; mem_wd_i = 5'd5; mem_wdata_i = 32'h5555;
        tick();
`ifdef ID_FORWARD_EN
        chk("lu_valid", 32'(bus.out_valid), 1);
        chk("lu_reg1", reg1_o, 32'h5555);
        chk("lu_reg2", reg2_o, 32'h5555);
`else
        chk("lu_stall", 32'(bus.out_valid), 0);
        mem_wreg_i = 1'b0;
        tick();
        chk("lu_valid", 32'(bus.out_valid), 1);
        chk("lu_reg1", reg1_o, 32'h1005);
        chk("lu_reg2", reg2_o, 32'h1005);
`endif
        chk("lu_aluop", 32'(aluop_o), 32'(EXE_ADD_OP));

        // addi x7,x0,1 while EX/MEM write x0: no hazard
        ex_wreg_i = 1'b1; ex_wd_i = 5'd0; ex_is_load_i = 1'b1;
        mem_wreg_i = 1'b1; mem_wd_i = 5'd0;
        push(32'h110, 32'h00100393);
        tick();
        chk("x0_valid", 32'(bus.out_valid), 1);
        chk("x0_reg1", reg1_o, 0);
        chk("x0_reg2", reg2_o, 1);
        ex_wreg_i = 1'b0; ex_is_load_i = 1'b0; mem_wreg_i = 1'b0;
        tick();

        // back-to-back: illegal, beq x1,x2,-4, lui x5,0xFFFFF
        bus.in_valid = 1'b1;
        bus.in_pc = 32'h300; bus.in_inst = 32'h0000007F;
        tick();
        bus.in_pc = 32'h304; bus.in_inst = 32'hFE208EE3;
        tick();
        chk("ill_valid", 32'(bus.out_valid), 1);
        chk("ill_pc", out_pc, 32'h300);
        chk("ill_flag", 32'(illegal_o), 1);
        chk("ill_wreg", 32'(wreg_o), 0);
        chk("ill_aluop", 32'(aluop_o), 0);
        bus.in_pc = 32'h308; bus.in_inst = 32'hFFFFF2B7;
        tick();
        bus.in_valid = 1'b0;
        chk("beq_pc", out_pc, 32'h304);
        chk("beq_imm", imm_o, 32'hFFFFFFFC);
        chk("beq_reg1", reg1_o, 32'h1001);
        chk("beq_reg2", reg2_o, 32'h1002);
        chk("beq_wreg", 32'(wreg_o), 0);
        chk("beq_ill", 32'(illegal_o), 0);
        tick();
        chk("lui_valid", 32'(bus.out_valid), 1);
        chk("lui_reg1", reg1_o, 0);
        chk("lui_reg2", reg2_o, 32'hFFFFF000);
        chk("lui_wd", 32'(wd_o), 5);
        chk("lui_wreg", 32'(wreg_o), 1);
        tick();
        chk("stream_idle", 32'(bus.out_valid), 0);

        // back-pressure: offer 4, expect 3 accepted
        bus.out_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_pc    = 32'h200 + 32'(4 * acc);
            bus.in_inst  = (32'(acc + 1) << 20) | (32'(acc + 1) << 7)
                           | 32'h13;
            if (bus.in_ready) acc++;
            tick();
        end
        bus.in_valid = 1'b0;
        chk("bp_accepted", 32'(acc), 3);
        chk("bp_ready", 32'(bus.in_ready), 0);
        chk("bp_pc0", out_pc, 32'h200);
        tick();
        chk("bp_hold_v", 32'(bus.out_valid), 1);
        chk("bp_hold_pc", out_pc, 32'h200);
        chk("bp_hold_r2", reg2_o, 1);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_pc1", out_pc, 32'h204);
        chk("bp_r2_1", reg2_o, 2);
        chk("bp_ready1", 32'(bus.in_ready), 1);
        tick();
        chk("bp_pc2", out_pc, 32'h208);
        chk("bp_r2_2", reg2_o, 3);
        tick();
        chk("bp_empty", 32'(bus.out_valid), 0);

        // flush with two buffered and the output register valid
        bus.out_ready = 1'b0;
        push(32'h400, 32'h00100093);
        push(32'h404, 32'h00200113);
        push(32'h408, 32'h00300193);
        chk("fl_pre_v", 32'(bus.out_valid), 1);
        chk("fl_pre_rdy", 32'(bus.in_ready), 0);
        flush_i = 1'b1; bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_pc = 32'h40C; bus.in_inst = 32'h00400213;
        tick();
        flush_i = 1'b0; bus.in_valid = 1'b0;
        chk("fl_valid", 32'(bus.out_valid), 0);
        chk("fl_ready", 32'(bus.in_ready), 1);
        chk("fl_empty", 32'(reg1_read_o), 0);
        tick();
        chk("fl_stale1", 32'(bus.out_valid), 0);
        tick();
        chk("fl_stale2", 32'(bus.out_valid), 0);

        // reset while holding an instruction and a valid output
        bus.out_ready = 1'b0;
        push(32'h500, 32'h00A06093);
        push(32'h504, 32'h00A06093);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rm_valid", 32'(bus.out_valid), 0);
        chk("rm_ready", 32'(bus.in_ready), 1);
        chk("rm_pc", out_pc, 0);
        bus.out_ready = 1'b1;
        tick();
        chk("rm_stale", 32'(bus.out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/id_pipe.md
# id_pipe

Parametrised RV32I instruction-decode stage that replaces the single-cycle combinational decoder between IF and EX. Accepts fetched instructions through a valid/ready handshake into a small input buffer. Decodes all RV32I base integer formats, resolves operands from the register file with EX/MEM bypass, and detects load-use hazards. Presents a registered ID/EX bundle to EX under valid/ready back-pressure.

## Interface
Parameters:
- `XLEN`, 32: datapath width; immediates sign-extend to `XLEN`.
- `SKID_DEPTH`, 2: input buffer entries (power of two, ≥2).
- `ALUOP_W`, 8: width of `aluop_o`.
- `ALUSEL_W`, 3: width of `alusel_o`.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `in_valid` in 1: fetch bundle valid.
- `in_ready` out 1: buffer can accept.
- `in_pc` in XLEN: instruction address.
- `in_inst` in 32: instruction word.
- `reg1_read_o`, `reg2_read_o` out 1: register file read enables.
- `reg1_addr_o`, `reg2_addr_o` out 5: rs1/rs2 of buffer head.
- `reg1_data_i`, `reg2_data_i` in XLEN: register file data, same cycle.
- `ex_wreg_i` in 1, `ex_wd_i` in 5, `ex_wdata_i` in XLEN, `ex_is_load_i` in 1: EX-stage writeback info.
- `mem_wreg_i` in 1, `mem_wd_i` in 5, `mem_wdata_i` in XLEN: MEM-stage writeback info.
- `flush_i` in 1: discard all held instructions (branch redirect).
- `out_valid` out 1, `out_ready` in 1: ID/EX handshake.
- `out_pc` out XLEN; `aluop_o` out ALUOP_W; `alusel_o` out ALUSEL_W.
- `reg1_o`, `reg2_o`, `imm_o` out XLEN: operands and immediate.
- `wd_o` out 5, `wreg_o` out 1: destination and write enable.
- `illegal_o` out 1: undecodable instruction.

## Operation
- Input buffer: circular FIFO of `SKID_DEPTH`; push on `in_valid && in_ready`; `in_ready = count != SKID_DEPTH` (registered count, no same-cycle full bypass).
- Head decoded combinationally. Opcodes: OP-IMM, OP, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE. Anything else: `illegal_o=1`, `wreg_o=0`, `aluop_o=NOP`; still forwarded to EX.
- Immediates: I, S, B (bit0=0), U (low 12 zero), J (bit0=0), all sign-extended from inst[31].
- Operand select: OP-IMM/LOAD/JALR: `reg2_o = imm`. LUI: `reg1_o = 0`, `reg2_o = imm`. AUIPC/JAL: `reg1_o = pc`. STORE/BRANCH: `reg2_o = rs2`, `imm_o` carries offset.
- Source priority per operand: x0 → 0; EX match (`ex_wreg_i && ex_wd_i==rs`) → `ex_wdata_i`; MEM match → `mem_wdata_i`; else regfile.
- Load-use hazard: EX match with `ex_is_load_i=1` on a used source. Head held; no bundle loaded. x0 never hazards.
- Advance: head pops into output register when head present, no hazard, and `(!out_valid || out_ready)`. If `out_ready` and no advance, `out_valid` falls.
- `flush_i`: next cycle FIFO empty, `out_valid=0`; same-cycle `in_valid` dropped; overrides advance.

## Timing
- Latency: 1 cycle, buffer head to `out_valid`; minimum 2 cycles, `in_valid` to `out_valid`.
- Throughput: 1 instr/cycle with `out_ready=1` and no hazards.
- Load-use: exactly one bubble per EX load match (EX advances).
- Output bundle stable while `out_valid && !out_ready`.
- Reset (`rst=0` at edge): FIFO pointers/count 0, `out_valid=0`, `in_ready=1` after reset; all registered outputs 0; `aluop_o/alusel_o` = NOP codes. Reset mid-transfer discards everything.

## Configuration
- `ID_FORWARD_EN` defined: EX/MEM bypass as above.
- Undefined: no bypass. Any used source matching an EX or MEM write (non-x0) stalls until clear; operands come only from the register file.

## Structure
- Shared package/defines: opcodes, funct3/funct7 codes, `EXE_*_OP` aluop codes, `EXE_RES_*` alusel codes, `ZeroWord`, `NOPRegAddr`, reset/enable constants.
- One sub-module: `id_fifo` (parametrised input buffer). Decode, bypass, hazard, and output register stay in `id_pipe`.

## Test plan
- `ori x1,x0,10` (0x00A06093), pc 0x100: next-but-one cycle `out_valid=1`, `reg1_o=0`, `reg2_o=10`, `wd_o=1`, `wreg_o=1`, `aluop_o=EXE_OR_OP`.
- Forward: inst reads x3, `ex_wd_i=3`, `ex_wdata_i=0x1234`, `mem_wd_i=3`, `mem_wdata_i=0x9999` → `reg1_o=0x1234` (without macro: stall while matches held).
- Load-use: `ex_is_load_i=1`, `ex_wd_i=5`, head `add x6,x5,x5` → one bubble, then `reg1_o=reg2_o=ex/mem data`.
- Back-pressure: `out_ready=0`, push 4 instrs, `SKID_DEPTH=2` → 3 accepted, `in_ready=0`; release → in-order delivery, none lost.
- Illegal 0x0000007F → `illegal_o=1`, `wreg_o=0`.
- `flush_i` with 2 buffered + output valid → next cycle `out_valid=0`, `in_ready=1`, no stale instruction emitted.
